// File: rtl/rcc_pkg.sv
// Shared RCC sequencer types and per-domain reset/clock timing defaults.
package rcc_pkg;

  localparam int RCC_SEQ_ST_W = 3;

  typedef enum logic [RCC_SEQ_ST_W-1:0] {
    SEQ_WAIT_PWR = 3'd0,
    SEQ_CLK_STOP = 3'd1,
    SEQ_ASSERT   = 3'd2,
    SEQ_HOLD     = 3'd3,
    SEQ_RUN      = 3'd4
  } rcc_seq_state_e;

  localparam int D1_RST_DURATION   = 10;
  localparam int D1_CLK_ON_DLY     = 8;
  localparam int D2_RST_DURATION   = 10;
  localparam int D2_CLK_ON_DLY     = 8;
  localparam int CPU1_RST_DURATION = 16;
  localparam int CPU1_CLK_ON_DLY   = 4;
  localparam int CPU2_RST_DURATION = 16;
  localparam int CPU2_CLK_ON_DLY   = 4;
  localparam int PER_RST_DURATION  = 8;
  localparam int PER_CLK_ON_DLY    = 2;
  localparam int SYS_RST_DURATION  = 32;
  localparam int SYS_CLK_ON_DLY    = 8;

  function automatic int rcc_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rcc_dly_cnt.sv
// Loadable down-counter for sequencer delays.
// Decrement saturates at zero.
module rcc_dly_cnt #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rcc_dom_rst_seq.sv
// Per-domain reset/clock sequencer: clock off, reset held,
// reset released, clock enabled after a settle delay.
module rcc_dom_rst_seq
  import rcc_pkg::*;
#(
  parameter int RST_DURATION = 10,
  parameter int CLK_ON_DLY   = 8,
  localparam int CW =
    $clog2(rcc_max(RST_DURATION, CLK_ON_DLY) + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwr_ok,
  input  logic rst_req,
  input  logic clr_flag,
  output logic dom_rst_n,
  output logic clk_en,
  output logic rst_flag,
  output logic busy
);

  localparam logic [CW-1:0] RST_LD =
    CW'(RST_DURATION - 1);
  localparam logic [CW-1:0] HOLD_LD =
    (CLK_ON_DLY > 0) ? CW'(CLK_ON_DLY - 1) : '0;

  rcc_seq_state_e state_q, state_d;
  logic           ld;
  logic [CW-1:0]  ld_val;
  logic           dec;
  logic           cnt_zero;
  logic           flag_set;

  rcc_dly_cnt #(.CW(CW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .load_val (ld_val),
    .dec      (dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEQ_WAIT_PWR;
      rst_flag <= 1'b1;
    end else begin
      state_q <= state_d;
      if (flag_set) begin
        rst_flag <= 1'b1;
      end else if (clr_flag) begin
        rst_flag <= 1'b0;
      end
    end
  end

  // Power loss overrides requests and expiry.
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    ld_val  = RST_LD;
    dec     = 1'b0;
    if ((state_q != SEQ_WAIT_PWR) && !pwr_ok) begin
      state_d = SEQ_WAIT_PWR;
    end else begin
      unique case (state_q)
        SEQ_WAIT_PWR: begin
          if (pwr_ok) begin
            state_d = SEQ_ASSERT;
            ld      = 1'b1;
          end
        end
        SEQ_CLK_STOP: begin
          state_d = SEQ_ASSERT;
          ld      = 1'b1;
        end
        SEQ_ASSERT: begin
          if (rst_req) begin
            ld = 1'b1;
          end else if (!cnt_zero) begin
            dec = 1'b1;
          end else if (CLK_ON_DLY > 0) begin
            state_d = SEQ_HOLD;
            ld      = 1'b1;
            ld_val  = HOLD_LD;
          end else begin
            state_d = SEQ_RUN;
          end
        end
        SEQ_HOLD: begin
          if (rst_req) begin
            state_d = SEQ_ASSERT;
            ld      = 1'b1;
          end else if (!cnt_zero) begin
            dec = 1'b1;
          end else begin
            state_d = SEQ_RUN;
          end
        end
        SEQ_RUN: begin
          if (rst_req) begin
            state_d = SEQ_CLK_STOP;
          end
        end
        default: begin
          state_d = SEQ_WAIT_PWR;
        end
      endcase
    end
  end

  assign flag_set = (state_d == SEQ_ASSERT) &&
                    (state_q != SEQ_ASSERT);

  always_comb begin
    dom_rst_n = 1'b0;
    clk_en    = 1'b0;
    busy      = 1'b1;
    unique case (1'b1)
      (state_q == SEQ_CLK_STOP),
      (state_q == SEQ_HOLD): begin
        dom_rst_n = 1'b1;
      end
      (state_q == SEQ_RUN): begin
        dom_rst_n = 1'b1;
        clk_en    = 1'b1;
        busy      = 1'b0;
      end
      default: begin
        dom_rst_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rcc_dom_rst_seq.sv
// Randomized check of three sequencer configurations
// against a cycle-count reference model.
module tb_rcc_dom_rst_seq;

  localparam int N = 3;
  localparam int RDV [N] = '{10, 10, 1};
  localparam int CDV [N] = '{8, 0, 8};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pwr_ok = 1'b0;
  logic rst_req = 1'b0;
  logic clr_flag = 1'b0;
  logic [N-1:0] dom_rst_n, clk_en, rst_flag, busy;

  int total = 0;
  int bad = 0;

  bit pw [N];
  int rl [N];
  int cl [N];
  bit stp [N];
  bit flg [N];

  always #5 clk = ~clk;

  rcc_dom_rst_seq #(.RST_DURATION(10), .CLK_ON_DLY(8)) u0 (
    .clk(clk), .rst_n(rst_n), .pwr_ok(pwr_ok),
    .rst_req(rst_req), .clr_flag(clr_flag),
    .dom_rst_n(dom_rst_n[0]), .clk_en(clk_en[0]),
    .rst_flag(rst_flag[0]), .busy(busy[0])
  );

  rcc_dom_rst_seq #(.RST_DURATION(10), .CLK_ON_DLY(0)) u1 (
    .clk(clk), .rst_n(rst_n), .pwr_ok(pwr_ok),
    .rst_req(rst_req), .clr_flag(clr_flag),
    .dom_rst_n(dom_rst_n[1]), .clk_en(clk_en[1]),
    .rst_flag(rst_flag[1]), .busy(busy[1])
  );

  rcc_dom_rst_seq #(.RST_DURATION(1), .CLK_ON_DLY(8)) u2 (
    .clk(clk), .rst_n(rst_n), .pwr_ok(pwr_ok),
    .rst_req(rst_req), .clr_flag(clr_flag),
    .dom_rst_n(dom_rst_n[2]), .clk_en(clk_en[2]),
    .rst_flag(rst_flag[2]), .busy(busy[2])
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < N; i++) begin
      pw[i] = 0; rl[i] = 0; cl[i] = 0;
      stp[i] = 0; flg[i] = 1;
    end
  endtask

  // rl: reset-low cycles left; cl: clock-off cycles
  // left after release; stp: one clock-stop cycle.
  task automatic mdl_step();
    for (int i = 0; i < N; i++) begin
      bit enter;
      enter = 0;
      if (!pwr_ok) begin
        pw[i] = 0; rl[i] = 0; cl[i] = 0; stp[i] = 0;
      end else if (!pw[i]) begin
        pw[i] = 1; enter = 1;
      end else if (stp[i]) begin
        stp[i] = 0; enter = 1;
      end else if (rl[i] > 0) begin
        if (rst_req) rl[i] = RDV[i];
        else begin
          rl[i]--;
          if (rl[i] == 0) cl[i] = CDV[i];
        end
      end else if (cl[i] > 0) begin
        if (rst_req) enter = 1;
        else cl[i]--;
      end else if (rst_req) begin
        stp[i] = 1;
      end
      if (enter) begin
        rl[i] = RDV[i]; cl[i] = 0;
      end
      flg[i] = enter | (flg[i] & !clr_flag);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      bit ern, ece;
      ern = pw[i] && (rl[i] == 0);
      ece = ern && (cl[i] == 0) && !stp[i];
      chk($sformatf("u%0d.dom_rst_n", i),
          32'(dom_rst_n[i]), 32'(ern));
      chk($sformatf("u%0d.clk_en", i),
          32'(clk_en[i]), 32'(ece));
      chk($sformatf("u%0d.busy", i),
          32'(busy[i]), 32'(!ece));
      chk($sformatf("u%0d.rst_flag", i),
          32'(rst_flag[i]), 32'(flg[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    mdl_step();
    #1;
    check_all();
  endtask

  int req_left = 0;
  int pwr_low = 0;

  initial begin
    mdl_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // Power-up with no requests: full latency per domain.
    for (int k = 0; k < 5; k++) tick();
    pwr_ok = 1'b1;
    for (int k = 0; k < 30; k++) tick();
    chk("pwrup_u0_run", 32'(clk_en[0]), 32'd1);
    chk("pwrup_u0_flag", 32'(rst_flag[0]), 32'd1);

    // Flag clear in RUN.
    clr_flag = 1'b1;
    tick();
    clr_flag = 1'b0;
    chk("clr_in_run", 32'(rst_flag[0]), 32'd0);

    // Sw reset pulse from RUN.
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    for (int k = 0; k < 25; k++) tick();

    // Randomized traffic.
    for (int k = 0; k < 4000; k++) begin
      if (pwr_low > 0) pwr_low--;
      else if ($urandom_range(0, 149) == 0)
        pwr_low = $urandom_range(1, 4);
      pwr_ok = (pwr_low == 0);
      if (req_left > 0) req_left--;
      else if ($urandom_range(0, 29) == 0)
        req_left = $urandom_range(1, 30);
      rst_req = (req_left > 0);
      clr_flag = ($urandom_range(0, 7) == 0);
      tick();
    end

    // Async reset while u0 holds reset low.
    pwr_ok = 1'b1; rst_req = 1'b1; clr_flag = 1'b0;
    tick();
    rst_req = 1'b0;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    mdl_reset();
    check_all();
    chk("arst_u0_rstn", 32'(dom_rst_n[0]), 32'd0);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) tick();
    chk("post_arst_u0_run", 32'(clk_en[0]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
